// File: rtl/mm_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : mm_result_collector
// Brief    : Gathers skewed per-lane results into packed rows, buffers them in
//            a small FIFO and streams them out over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module mm_result_collector #(
  parameter int N     = 16,
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  row_total,
  input  logic [DW*N-1:0]   lane_data,
  input  logic [N-1:0]      lane_valid,
  output logic              stall,
  output logic [DW*N-1:0]   out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  rows_done,
  output logic              err_dup,
  output logic              err_ovf
);

  localparam int                   c_ptr_w     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_ptr_w-1:0]   c_ptr_one   = c_ptr_w'(1);
  localparam logic [c_ptr_w:0]     c_cnt_one   = (c_ptr_w + 1)'(1);
  localparam logic [c_ptr_w:0]     c_depth     = (c_ptr_w + 1)'(DEPTH);
  localparam logic [c_ptr_w:0]     c_stall_lvl = (c_ptr_w + 1)'(DEPTH - 1);
  localparam logic [CNT_W-1:0]     c_row_one   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [N-1:0]         r_mask;
  logic [DW-1:0]        r_cap [N];
  logic [DW*N-1:0]      r_mem [DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr;
  logic [c_ptr_w-1:0]   r_rd_ptr;
  logic [c_ptr_w:0]     r_count;
  logic [c_ptr_w:0]     w_count_nxt;
  logic [CNT_W-1:0]     r_total;
  logic [CNT_W-1:0]     r_rows_done;
  logic                 r_err_dup;
  logic                 r_err_ovf;
  logic                 r_done;
  logic                 r_stall;

  logic                 w_accept_start;
  logic                 w_capture;
  logic [N-1:0]         w_hit;
  logic [N-1:0]         w_new;
  logic                 w_dup;
  logic                 w_complete;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_ovf;
  logic [DW*N-1:0]      w_row;

  assign w_accept_start = (r_state == S_IDLE) && start;
  // Once the job's row count is reached, lanes are ignored so rows_done never passes the total.
  assign w_capture      = (r_state == S_RUN) && (r_rows_done != r_total);
  assign w_hit          = lane_valid & {N{w_capture}};
  assign w_new          = w_hit & ~r_mask;
  assign w_dup          = |(w_hit & r_mask);
  assign w_complete     = w_capture && (&(r_mask | w_hit));

  assign out_valid      = (r_count != '0);
  assign w_pop          = out_valid && out_ready;
  assign w_push         = w_complete && ((r_count < c_depth) || w_pop);
  assign w_ovf          = w_complete && !w_push;

  // A duplicate on an already-captured lane keeps the first value.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      assign w_row[gi*DW +: DW] = r_mask[gi] ? r_cap[gi] : lane_data[gi*DW +: DW];
    end
  endgenerate

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + c_cnt_one;
      2'b01:   w_count_nxt = r_count - c_cnt_one;
      default: w_count_nxt = r_count;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = (row_total == '0) ? S_DONE : S_RUN;
      S_RUN:   if (r_rows_done == r_total) w_state_nxt = S_DRAIN;
      S_DRAIN: if (r_count == '0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mask      <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_total     <= '0;
      r_rows_done <= '0;
      r_err_dup   <= 1'b0;
      r_err_ovf   <= 1'b0;
      r_done      <= 1'b0;
      r_stall     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == S_DONE);
      r_stall <= (w_count_nxt >= c_stall_lvl);
      r_count <= w_count_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      if (w_accept_start) begin
        r_total     <= row_total;
        r_rows_done <= '0;
        r_err_dup   <= 1'b0;
        r_err_ovf   <= 1'b0;
        r_mask      <= '0;
      end else begin
        if (w_complete) begin
          r_mask      <= '0;
          r_rows_done <= r_rows_done + c_row_one;
        end else begin
          r_mask <= r_mask | w_new;
        end
        if (w_dup) r_err_dup <= 1'b1;
        if (w_ovf) r_err_ovf <= 1'b1;
      end
    end
  end

  // Storage needs no reset: the mask and FIFO count decide what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (w_new[i]) r_cap[i] <= lane_data[i*DW +: DW];
    end
    if (w_push) r_mem[r_wr_ptr] <= w_row;
  end

  assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
  assign stall     = r_stall;
  assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done      = r_done;
  assign rows_done = r_rows_done;
  assign err_dup   = r_err_dup;
  assign err_ovf   = r_err_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mm_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_mm_result_collector
// Brief    : Self-checking bench for mm_result_collector against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mm_result_collector;

  localparam int N     = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int W     = DW * N;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] row_total;
  logic [W-1:0]     lane_data;
  logic [N-1:0]     lane_valid;
  logic             stall;
  logic [W-1:0]     out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] rows_done;
  logic             err_dup;
  logic             err_ovf;

  int n_vec = 0;
  int n_err = 0;

  mm_result_collector #(.N(N), .DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .row_total  (row_total),
    .lane_data  (lane_data),
    .lane_valid (lane_valid),
    .stall      (stall),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .rows_done  (rows_done),
    .err_dup    (err_dup),
    .err_ovf    (err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: job phase (0 idle, 1 run, 2 drain, 3 done), a queue of rows.
  int           m_phase = 0;
  int           m_total = 0;
  int           m_rows  = 0;
  int           m_rows_pre;
  int           m_sz;
  bit           m_pop;
  bit           m_comp;
  logic [N-1:0] m_mask = '0;
  logic [DW-1:0] m_cap [N];
  logic [W-1:0] m_row;
  logic [W-1:0] m_q [$];
  bit           m_dup = 0;
  bit           m_ovf = 0;
  bit           m_done = 0;
  bit           m_stall = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_rows = 0; m_total = 0; m_mask = '0;
      m_q.delete(); m_dup = 0; m_ovf = 0; m_done = 0; m_stall = 0;
    end else begin
      m_sz       = m_q.size();
      m_pop      = (m_sz > 0) && out_ready;
      m_rows_pre = m_rows;
      m_done     = (m_phase == 3);
      m_comp     = 0;
      if (m_phase == 1 && m_rows < m_total) begin
        if ((lane_valid & m_mask) != '0) m_dup = 1;
        m_comp = ((lane_valid | m_mask) == {N{1'b1}});
        for (int i = 0; i < N; i++) begin
          m_row[i*DW +: DW] = m_mask[i] ? m_cap[i] : lane_data[i*DW +: DW];
          if (lane_valid[i] && !m_mask[i]) begin
            m_cap[i]  = lane_data[i*DW +: DW];
            m_mask[i] = 1'b1;
          end
        end
      end
      if (m_pop) void'(m_q.pop_front());
      if (m_comp) begin
        if (m_sz < DEPTH || m_pop) m_q.push_back(m_row);
        else m_ovf = 1;
        m_rows++;
        m_mask = '0;
      end
      case (m_phase)
        0: if (start) begin
             m_total = int'(row_total); m_rows = 0; m_dup = 0; m_ovf = 0; m_mask = '0;
             m_phase = (row_total == '0) ? 3 : 1;
           end
        1: if (m_rows_pre == m_total) m_phase = 2;
        2: if (m_sz == 0) m_phase = 3;
        default: m_phase = 0;
      endcase
      m_stall = (m_q.size() >= DEPTH - 1);
    end
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("out_valid", W'(out_valid), W'(m_q.size() > 0));
    check("out_data",  out_data, (m_q.size() > 0) ? m_q[0] : '0);
    check("stall",     W'(stall),     W'(m_stall));
    check("busy",      W'(busy),      W'(m_phase == 1 || m_phase == 2));
    check("done",      W'(done),      W'(m_done));
    check("rows_done", W'(rows_done), W'(m_rows));
    check("err_dup",   W'(err_dup),   W'(m_dup));
    check("err_ovf",   W'(err_ovf),   W'(m_ovf));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic rand_lanes();
    for (int i = 0; i < N; i++) lane_data[i*DW +: DW] = $urandom;
  endtask

  task automatic start_job(input int total);
    start = 1'b1; row_total = CNT_W'(total);
    tick();
    start = 1'b0;
  endtask

  task automatic full_row();
    rand_lanes(); lane_valid = '1;
    tick();
    lane_valid = '0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    bit seen = 0;
    for (int k = 0; k < bound && !seen; k++) begin
      tick();
      if (done) seen = 1;
    end
    check(tag, W'(seen), W'(1));
  endtask

  logic [W-1:0] exp_row;
  int           pops;

  initial begin
    rst_n = 1'b0; start = 1'b0; row_total = '0; lane_data = '0;
    lane_valid = '0; out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single row, all lanes at once
    start_job(1);
    for (int i = 0; i < N; i++) lane_data[i*DW +: DW] = DW'(i + 1);
    exp_row = lane_data;
    lane_valid = '1; out_ready = 1'b1;
    tick();
    lane_valid = '0;
    check("t1_valid", W'(out_valid), W'(1));
    check("t1_data", out_data, exp_row);
    tick();
    check("t1_empty", W'(out_valid), W'(0));
    wait_done("t1_done", 20);
    check("t1_rows", W'(rows_done), W'(1));

    // Skewed lanes with a duplicate on lane 0
    start_job(2);
    lane_valid = 16'h0001; lane_data[DW-1:0] = 32'hA; tick();
    lane_data[DW-1:0] = 32'hB; tick();
    for (int i = 1; i < N; i++) begin
      rand_lanes(); lane_valid = '0; lane_valid[i] = 1'b1;
      tick();
    end
    lane_valid = '0;
    check("t2_lane0", W'(out_data[DW-1:0]), W'(32'hA));
    check("t2_dup", W'(err_dup), W'(1));
    full_row();
    wait_done("t2_done", 20);

    // Back-pressure with overflow
    out_ready = 1'b0;
    start_job(5);
    for (int r = 0; r < 5; r++) begin
      full_row();
      if (r == 2) check("t3_stall", W'(stall), W'(1));
    end
    check("t3_ovf", W'(err_ovf), W'(1));
    tick();
    out_ready = 1'b1;
    pops = 0;
    for (int k = 0; k < 30; k++) begin
      if (out_valid) pops++;
      tick();
      if (done) break;
    end
    check("t3_pops", W'(pops), W'(4));

    // Push and pop together with the FIFO full
    out_ready = 1'b0;
    start_job(6);
    for (int r = 0; r < 4; r++) full_row();
    out_ready = 1'b1;
    full_row();
    out_ready = 1'b0;
    check("t4_no_ovf", W'(err_ovf), W'(0));
    check("t4_full", W'(stall), W'(1));
    full_row();
    out_ready = 1'b1;
    wait_done("t4_done", 30);

    // Zero-row job
    start_job(0);
    check("t5_done_early", W'(done), W'(0));
    tick();
    check("t5_done", W'(done), W'(1));
    check("t5_busy", W'(busy), W'(0));
    tick();

    // Start during RUN is ignored
    start_job(2);
    rand_lanes(); lane_valid = 16'h00FF; tick();
    lane_valid = '0; start = 1'b1; row_total = 16'd9; tick();
    start = 1'b0;
    rand_lanes(); lane_valid = 16'hFF00; tick();
    full_row();
    wait_done("t6_done", 20);
    check("t6_rows", W'(rows_done), W'(2));

    // Reset mid-DRAIN
    out_ready = 1'b0;
    start_job(1);
    full_row();
    tick();
    check("t7_busy", W'(busy), W'(1));
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("t7_data", out_data, '0);
    check("t7_valid", W'({out_valid, stall, busy, done, err_dup, err_ovf}), W'(0));
    check("t7_rows", W'(rows_done), W'(0));

    // lane_valid in IDLE captures nothing
    out_ready = 1'b1;
    rand_lanes(); lane_valid = '1; tick(); tick();
    lane_valid = '0;
    start_job(1);
    rand_lanes(); lane_valid = 16'h7FFF; tick();
    check("t8_partial", W'(out_valid), W'(0));
    rand_lanes(); lane_valid = 16'h8000; tick();
    lane_valid = '0;
    check("t8_row", W'(out_valid), W'(1));
    wait_done("t8_done", 20);

    // Randomized jobs
    for (int j = 0; j < 20; j++) begin
      start_job($urandom_range(1, 6));
      for (int k = 0; k < 600; k++) begin
        rand_lanes();
        lane_valid = (stall && ($urandom_range(0, 3) != 0)) ? '0 : N'($urandom & $urandom);
        out_ready  = ($urandom_range(0, 3) != 0);
        tick();
        if (done) break;
      end
      lane_valid = '0;
      check("rnd_done", W'(done), W'(1));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
